gty_bringup_sequencer: RTL and testbench
========================================

GTY_BRINGUP_SEQUENCER -- requirements
Module: gty_bringup_sequencer

Interface
REQ-001 SHALL have parameter RESET_PULSE_CYCLES, default 16: gtwiz reset_all pulse width in pl_clk0 cycles.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000: per-wait-state timeout in cycles.
REQ-003 SHALL have parameter MAX_RETRIES, default 3: failed attempts before FAULT.
REQ-004 SHALL have port pl_clk0, input, 1: free-running 100 MHz clock; the only clock.
REQ-005 SHALL have port reset_in, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port enable_in, input, 1: bring-up request; asynchronous.
REQ-007 SHALL have the following asynchronous 1-bit status inputs: gtpowergood_in, txpmaresetdone_in, rxpmaresetdone_in, userclk_tx_active_in, userclk_rx_active_in, reset_tx_done_in, reset_rx_done_in, reset_rx_cdr_stable_in.
REQ-008 SHALL have the following 1-bit reset outputs to the transceiver wizard: gtwiz_reset_all_out, gtwiz_userclk_tx_reset_out, gtwiz_userclk_rx_reset_out.
REQ-009 SHALL have outputs link_up_out (1), fault_out (1), state_out (3), retry_cnt_out (4) and link_loss_cnt_out (16).

Function
REQ-010 SHALL pass every asynchronous input through a 2-flop synchronizer; all "sees X" below refers to the synchronized value.
REQ-011 SHALL implement states IDLE=0, WAIT_PG=1, RESET_ALL=2, WAIT_PMA=3, WAIT_DONE=4, RUNNING=5, RETRY=6, FAULT=7; state_out reflects the current state.
REQ-012 SHALL transition IDLE->WAIT_PG when enable_in is seen high.
REQ-013 SHALL transition WAIT_PG->RESET_ALL when gtpowergood_in is seen high.
REQ-014 SHALL, in RESET_ALL, hold gtwiz_reset_all_out=1 for exactly RESET_PULSE_CYCLES cycles, then go to WAIT_PMA.
REQ-015 SHALL transition WAIT_PMA->WAIT_DONE when txpmaresetdone_in and rxpmaresetdone_in are both seen high.
REQ-016 SHALL drive gtwiz_userclk_tx_reset_out and gtwiz_userclk_rx_reset_out =1 in all states except WAIT_DONE and RUNNING.
REQ-017 SHALL transition WAIT_DONE->RUNNING when userclk_tx_active_in, userclk_rx_active_in, reset_tx_done_in, reset_rx_done_in and reset_rx_cdr_stable_in are all seen high in the same cycle.
REQ-018 SHALL drive gtwiz_reset_all_out=1 in IDLE, RESET_ALL, RETRY and FAULT, and 0 elsewhere.
REQ-019 SHALL use a timeout counter that clears on every state entry.
REQ-020 SHALL transition WAIT_PG, WAIT_PMA or WAIT_DONE to RETRY on the cycle after the timeout counter reaches TIMEOUT_CYCLES-1 without the exit condition being met; if the exit condition and the timeout coincide, the exit condition wins.
REQ-021 SHALL handle RETRY (one cycle) as follows: increment retry_cnt_out; if the incremented value equals MAX_RETRIES go to FAULT, else go to RESET_ALL.
REQ-022 SHALL drive link_up_out=1 only in RUNNING, and SHALL clear retry_cnt_out to 0 on entry to RUNNING.
REQ-023 SHALL, in RUNNING, if gtpowergood_in, reset_tx_done_in or reset_rx_done_in is seen low: increment link_loss_cnt_out (saturating at 0xFFFF) and go to RETRY.
REQ-024 SHALL hold FAULT with fault_out=1 until enable_in is seen low.
REQ-025 SHALL transition from any state other than IDLE to IDLE on the next cycle when enable_in is seen low, with priority over all other transitions.
REQ-026 SHALL clear retry_cnt_out and fault_out on entry to IDLE; link_loss_cnt_out is cleared only by reset_in.
REQ-027 SHALL register all outputs; outputs change one cycle after the state transition.

Reset
REQ-028 SHALL, while reset_in=1, force: state IDLE, gtwiz_reset_all_out=1, both userclk resets =1, link_up_out=0, fault_out=0, retry_cnt_out=0, link_loss_cnt_out=0, timeout counter 0, synchronizers 0.
REQ-029 SHALL, when reset_in is asserted mid-sequence, abort immediately with no partial pulse completion; after release, resume from IDLE.

Verification
REQ-030 Nominal bring-up (RESET_PULSE_CYCLES=4, TIMEOUT_CYCLES=32, MAX_RETRIES=2): enable=1, all statuses rise promptly -> reset_all high exactly 4 cycles in RESET_ALL; RUNNING reached; link_up_out=1; retry_cnt_out=0.
REQ-031 Timeout to fault: rxpmaresetdone held 0 -> two 32-cycle WAIT_PMA timeouts; retry_cnt_out=1 then 2; state_out=7; fault_out=1. Deassert enable -> IDLE; fault_out=0; retry_cnt_out=0.
REQ-032 Link loss: from RUNNING, drop reset_rx_done for 1 cycle -> link_loss_cnt_out=1; RETRY then RESET_ALL; link_up_out=0; recovers to RUNNING.
REQ-033 Coincidence: exit condition met on the exact timeout cycle -> advances to the next state; no RETRY.
REQ-034 Reset mid-RESET_ALL (2nd pulse cycle): assert reset_in -> all outputs at REQ-028 values; after release with enable=1 -> full 4-cycle pulse re-issued.
REQ-035 Saturation: force 65536 link losses (preload via hierarchy allowed) -> link_loss_cnt_out stays 0xFFFF.

Source files
------------

// File: rtl/gty_bringup_sequencer.sv
// gty_bringup_sequencer: GTY transceiver bring-up FSM with timeouts, retries and link-loss recovery
module gty_bringup_sequencer #(
  parameter int RESET_PULSE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES     = 1000000,
  parameter int MAX_RETRIES        = 3
) (
  input  logic        pl_clk0,
  input  logic        reset_in,
  input  logic        enable_in,
  input  logic        gtpowergood_in,
  input  logic        txpmaresetdone_in,
  input  logic        rxpmaresetdone_in,
  input  logic        userclk_tx_active_in,
  input  logic        userclk_rx_active_in,
  input  logic        reset_tx_done_in,
  input  logic        reset_rx_done_in,
  input  logic        reset_rx_cdr_stable_in,
  output logic        gtwiz_reset_all_out,
  output logic        gtwiz_userclk_tx_reset_out,
  output logic        gtwiz_userclk_rx_reset_out,
  output logic        link_up_out,
  output logic        fault_out,
  output logic [2:0]  state_out,
  output logic [3:0]  retry_cnt_out,
  output logic [15:0] link_loss_cnt_out
);
  typedef enum logic [2:0] {IDLE, WAIT_PG, RESET_ALL, WAIT_PMA, WAIT_DONE, RUNNING, RETRY, FAULT} state_t;
  localparam logic [31:0] TO = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] RP = 32'(RESET_PULSE_CYCLES - 1);
  localparam logic [3:0]  MR = 4'(MAX_RETRIES);
  state_t state, nxt;
  logic [8:0] s1, s2;
  logic [31:0] tmr;
  logic en, pg, txp, rxp, utx, urx, txd, rxd, cdr, tmo;
  logic [3:0] rinc;
  assign {en, pg, txp, rxp, utx, urx, txd, rxd, cdr} = s2;
  assign tmo = tmr == TO;
  assign rinc = retry_cnt_out + 4'd1;
  assign state_out = state;
  always_ff @(posedge pl_clk0 or posedge reset_in)
    if (reset_in) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {enable_in, gtpowergood_in, txpmaresetdone_in, rxpmaresetdone_in, userclk_tx_active_in,
             userclk_rx_active_in, reset_tx_done_in, reset_rx_done_in, reset_rx_cdr_stable_in};
      s2 <= s1;
    end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = en ? WAIT_PG : IDLE;
      WAIT_PG:   nxt = pg ? RESET_ALL : tmo ? RETRY : WAIT_PG;
      RESET_ALL: nxt = tmr == RP ? WAIT_PMA : RESET_ALL;
      WAIT_PMA:  nxt = (txp && rxp) ? WAIT_DONE : tmo ? RETRY : WAIT_PMA;
      WAIT_DONE: nxt = (utx && urx && txd && rxd && cdr) ? RUNNING : tmo ? RETRY : WAIT_DONE;
      RUNNING:   nxt = (!pg || !txd || !rxd) ? RETRY : RUNNING;
      RETRY:     nxt = rinc == MR ? FAULT : RESET_ALL;
      default:   nxt = FAULT;
    endcase
    if (!en) nxt = IDLE;
  end
  always_ff @(posedge pl_clk0 or posedge reset_in)
    if (reset_in) begin
      state                      <= IDLE;
      tmr                        <= '0;
      retry_cnt_out              <= '0;
      link_loss_cnt_out          <= '0;
      gtwiz_reset_all_out        <= 1'b1;
      gtwiz_userclk_tx_reset_out <= 1'b1;
      gtwiz_userclk_rx_reset_out <= 1'b1;
      link_up_out                <= 1'b0;
      fault_out                  <= 1'b0;
    end else begin
      state <= nxt;
      tmr   <= (nxt != state) ? '0 : tmr + 32'd1;
      if (nxt == IDLE || nxt == RUNNING) retry_cnt_out <= '0;
      else if (state == RETRY) retry_cnt_out <= rinc;
      if (state == RUNNING && nxt == RETRY && link_loss_cnt_out != 16'hFFFF)
        link_loss_cnt_out <= link_loss_cnt_out + 16'd1;
      gtwiz_reset_all_out        <= state inside {IDLE, RESET_ALL, RETRY, FAULT};
      gtwiz_userclk_tx_reset_out <= !(state inside {WAIT_DONE, RUNNING});
      gtwiz_userclk_rx_reset_out <= !(state inside {WAIT_DONE, RUNNING});
      link_up_out                <= state == RUNNING;
      fault_out                  <= state == FAULT;
    end
endmodule

// File: tb/tb_gty_bringup_sequencer.sv
// tb_gty_bringup_sequencer: directed table and sequence checks for gty_bringup_sequencer
module tb_gty_bringup_sequencer;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, pg = 1'b0, txp = 1'b0, rxp = 1'b0;
  logic utx = 1'b0, urx = 1'b0, txd = 1'b0, rxd = 1'b0, cdr = 1'b0;
  logic rall, utx_rst, urx_rst, link_up, fault;
  logic [2:0] st;
  logic [3:0] rty;
  logic [15:0] loss;
  int pass = 0, total = 0;
  typedef struct {
    logic en, pg, pma, act;
    int cyc;
    logic [2:0] st;
    logic rall, ucl, link;
    logic [3:0] rty;
  } vec_t;
  vec_t v[9];
  always #5 clk = ~clk;
  gty_bringup_sequencer #(.RESET_PULSE_CYCLES(4), .TIMEOUT_CYCLES(32), .MAX_RETRIES(2)) dut (
    .pl_clk0(clk), .reset_in(rst), .enable_in(en), .gtpowergood_in(pg),
    .txpmaresetdone_in(txp), .rxpmaresetdone_in(rxp),
    .userclk_tx_active_in(utx), .userclk_rx_active_in(urx),
    .reset_tx_done_in(txd), .reset_rx_done_in(rxd), .reset_rx_cdr_stable_in(cdr),
    .gtwiz_reset_all_out(rall), .gtwiz_userclk_tx_reset_out(utx_rst),
    .gtwiz_userclk_rx_reset_out(urx_rst), .link_up_out(link_up), .fault_out(fault),
    .state_out(st), .retry_cnt_out(rty), .link_loss_cnt_out(loss)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int i = 0;
    while (st !== s && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(name, 32'(st), 32'(s));
  endtask
  task automatic set_act(input logic a);
    {utx, urx, txd, rxd, cdr} = {5{a}};
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic measure_pulse(input string tag);
    int ra = 0, hi = 0;
    logic lo = 1'b0;
    for (int i = 0; i < 100 && st !== 3'd5; i++) begin
      @(negedge clk);
      if (st == 3'd2) ra++;
      if (!rall) lo = 1'b1;
      else if (lo) hi++;
    end
    chk({tag, "_running"}, 32'(st), 32'd5);
    chk({tag, "_ra_cycles"}, 32'(ra), 32'd4);
    chk({tag, "_pulse_width"}, 32'(hi), 32'd4);
    @(negedge clk);
    chk({tag, "_link_up"}, 32'(link_up), 32'd1);
    chk({tag, "_retry"}, 32'(rty), 32'd0);
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(st), 32'd0);
    chk({tag, "_rall"}, 32'(rall), 32'd1);
    chk({tag, "_utx_rst"}, 32'(utx_rst), 32'd1);
    chk({tag, "_urx_rst"}, 32'(urx_rst), 32'd1);
    chk({tag, "_link"}, 32'(link_up), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_retry"}, 32'(rty), 32'd0);
    chk({tag, "_loss"}, 32'(loss), 32'd0);
  endtask
  initial begin
    v[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 5,  3'd0, 1'b1, 1'b1, 1'b0, 4'd0};
    v[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 5,  3'd1, 1'b0, 1'b1, 1'b0, 4'd0};
    v[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 12, 3'd3, 1'b0, 1'b1, 1'b0, 4'd0};
    v[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 5,  3'd4, 1'b0, 1'b0, 1'b0, 4'd0};
    v[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 5,  3'd5, 1'b0, 1'b0, 1'b1, 4'd0};
    v[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 5,  3'd0, 1'b1, 1'b1, 1'b0, 4'd0};
    v[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 12, 3'd5, 1'b0, 1'b0, 1'b1, 4'd0};
    v[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 4,  3'd2, 1'b1, 1'b1, 1'b0, 4'd1};
    v[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 5,  3'd0, 1'b1, 1'b1, 1'b0, 4'd0};
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      en = v[i].en;
      pg = v[i].pg;
      {txp, rxp} = {2{v[i].pma}};
      set_act(v[i].act);
      repeat (v[i].cyc) @(negedge clk);
      chk($sformatf("vec%0d_state", i), 32'(st), 32'(v[i].st));
      chk($sformatf("vec%0d_rall", i), 32'(rall), 32'(v[i].rall));
      chk($sformatf("vec%0d_ucl_rst", i), 32'({utx_rst, urx_rst}), 32'({2{v[i].ucl}}));
      chk($sformatf("vec%0d_link", i), 32'(link_up), 32'(v[i].link));
      chk($sformatf("vec%0d_retry", i), 32'(rty), 32'(v[i].rty));
      chk($sformatf("vec%0d_fault", i), 32'(fault), 32'd0);
    end
    chk("table_loss", 32'(loss), 32'd1);
    // nominal bring-up pulse width from a fresh reset
    pg = 1'b1; txp = 1'b1; rxp = 1'b1; set_act(1'b1);
    do_reset();
    en = 1'b1;
    measure_pulse("nominal");
    // timeout to fault
    en = 1'b0; rxp = 1'b0;
    do_reset();
    en = 1'b1;
    wait_state(3'd3, 100, "to_enter_pma");
    begin
      int n = 0;
      while (st === 3'd3 && n < 100) begin
        n++;
        @(negedge clk);
      end
      chk("to_pma_len", 32'(n), 32'd32);
    end
    chk("to_retry1", 32'(st), 32'd6);
    @(negedge clk);
    chk("to_retry_cnt1", 32'(rty), 32'd1);
    chk("to_reissue", 32'(st), 32'd2);
    wait_state(3'd6, 100, "to_retry2");
    @(negedge clk);
    chk("to_fault_state", 32'(st), 32'd7);
    chk("to_retry_cnt2", 32'(rty), 32'd2);
    @(negedge clk);
    chk("to_fault_out", 32'(fault), 32'd1);
    en = 1'b0;
    repeat (5) @(negedge clk);
    chk("to_idle", 32'(st), 32'd0);
    chk("to_fault_clr", 32'(fault), 32'd0);
    chk("to_retry_clr", 32'(rty), 32'd0);
    // link loss from a one-cycle reset_rx_done drop
    rxp = 1'b1; en = 1'b1;
    wait_state(3'd5, 100, "ll_running");
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    wait_state(3'd6, 10, "ll_retry");
    @(negedge clk);
    chk("ll_reset_all", 32'(st), 32'd2);
    chk("ll_loss_cnt", 32'(loss), 32'd1);
    chk("ll_link_down", 32'(link_up), 32'd0);
    chk("ll_retry_cnt", 32'(rty), 32'd1);
    wait_state(3'd5, 100, "ll_recover");
    chk("ll_retry_clr", 32'(rty), 32'd0);
    // exit condition lands on the final timeout cycle
    en = 1'b0;
    repeat (5) @(negedge clk);
    rxp = 1'b0; en = 1'b1;
    wait_state(3'd3, 100, "co_enter_pma");
    repeat (29) @(negedge clk);
    rxp = 1'b1;
    repeat (3) @(negedge clk);
    chk("co_exit_wins", 32'(st), 32'd4);
    // one cycle later the timeout wins
    en = 1'b0;
    repeat (5) @(negedge clk);
    rxp = 1'b0; en = 1'b1;
    wait_state(3'd3, 100, "late_enter_pma");
    repeat (30) @(negedge clk);
    rxp = 1'b1;
    repeat (2) @(negedge clk);
    chk("late_exit_retry", 32'(st), 32'd6);
    // reset during the second reset_all pulse cycle
    en = 1'b0;
    repeat (5) @(negedge clk);
    en = 1'b1;
    wait_state(3'd2, 100, "mid_enter_ra");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_vals("mid_reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    measure_pulse("after_reset");
    // link loss counter saturation
    @(negedge clk);
    force dut.link_loss_cnt_out = 16'hFFFE;
    @(negedge clk);
    release dut.link_loss_cnt_out;
    @(negedge clk);
    chk("sat_preload", 32'(loss), 32'hFFFE);
    txd = 1'b0;
    @(negedge clk);
    txd = 1'b1;
    wait_state(3'd6, 10, "sat_retry1");
    @(negedge clk);
    chk("sat_reach", 32'(loss), 32'hFFFF);
    wait_state(3'd5, 100, "sat_recover");
    pg = 1'b0;
    @(negedge clk);
    pg = 1'b1;
    wait_state(3'd6, 10, "sat_retry2");
    @(negedge clk);
    chk("sat_hold", 32'(loss), 32'hFFFF);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
